// File: rtl/dcache_pkg.sv
// ============================================================================
// dcache_pkg : shared types and constants for the L1 data cache controller
// Rev 1.0
// ============================================================================
`default_nettype none

package dcache_pkg;

    localparam int OFFSET_W    = 5;
    localparam int WORD_LSB    = 2;
    localparam int WORD_MSB    = 4;
    localparam int WORD_W      = 32;
    localparam int WORD_SEL_W  = WORD_MSB - WORD_LSB + 1;
    // Tag field is sized for the widest supported address; only the low TAG_W bits are live.
    localparam int TAG_FIELD_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WB     = 2'd1,
        ALLOC  = 2'd2,
        REFILL = 2'd3
    } state_t;

    typedef struct packed {
        logic                   valid;
        logic                   dirty;
        logic [TAG_FIELD_W-1:0] tag;
    } tag_entry_t;

endpackage

`default_nettype wire

// File: rtl/dcache_sram.sv
// ============================================================================
// dcache_sram : tag + data storage, asynchronous read, synchronous line/word write
// Rev 1.0
// ============================================================================
`default_nettype none

module dcache_sram
    import dcache_pkg::*;
#(
    parameter int NUM_SETS = 32,
    parameter int IDX_W    = 5,
    parameter int TAG_W    = 22,
    parameter int LINE_W   = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IDX_W-1:0]      idx,
    output tag_entry_t            entry,
    output logic [LINE_W-1:0]     line,
    input  logic                  line_we,
    input  logic [TAG_W-1:0]      line_tag,
    input  logic [LINE_W-1:0]     line_data,
    input  logic                  word_we,
    input  logic [WORD_SEL_W-1:0] word_sel,
    input  logic [WORD_W-1:0]     word_data
);

    logic              valid_q [NUM_SETS];
    logic              dirty_q [NUM_SETS];
    logic [TAG_W-1:0]  tag_q   [NUM_SETS];
    logic [LINE_W-1:0] data_q  [NUM_SETS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SETS; i++) begin
                valid_q[i] <= 1'b0;
                dirty_q[i] <= 1'b0;
            end
        end else if (line_we) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (word_we) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // Contents are don't-care until the valid bit is set, so no reset here.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_q[idx]  <= line_tag;
            data_q[idx] <= line_data;
        end else if (word_we) begin
            data_q[idx][{word_sel, 5'b00000} +: WORD_W] <= word_data;
        end
    end

    always_comb begin
        entry                = '0;
        entry.valid          = valid_q[idx];
        entry.dirty          = dirty_q[idx];
        entry.tag[TAG_W-1:0] = tag_q[idx];
    end

    assign line = data_q[idx];

endmodule

`default_nettype wire

// File: rtl/dcache_ctrl.sv
// ============================================================================
// dcache_ctrl : direct-mapped write-back/write-allocate L1 D-cache controller
// Optional DCACHE_STATS_EN adds saturating hit/miss counters.  Rev 1.0
// ============================================================================
`default_nettype none

module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_SETS = 32,
    parameter int LINE_W   = 256,
    parameter int ADDR_W   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] p_addr_i,
    input  logic [31:0]       p_data_i,
    input  logic              p_memread_i,
    input  logic              p_memwrite_i,
    output logic [31:0]       p_data_o,
    output logic              p_stall_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    input  logic [LINE_W-1:0] mem_data_i,
`ifdef DCACHE_STATS_EN
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o,
`endif
    input  logic              mem_ack_i
);

    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int TAG_W  = ADDR_W - OFFSET_W - IDX_W;
    localparam int IDX_HI = OFFSET_W + IDX_W - 1;

    logic                   request;
    logic [IDX_W-1:0]       idx;
    logic [TAG_W-1:0]       req_tag;
    logic [TAG_FIELD_W-1:0] req_tag_ext;
    logic [WORD_SEL_W-1:0]  word_sel;
    tag_entry_t             entry;
    logic [LINE_W-1:0]      line;
    logic                   hit;
    logic                   victim_dirty;
    logic [ADDR_W-1:0]      victim_addr;
    logic [ADDR_W-1:0]      req_addr;
    logic                   line_we;
    logic                   word_we;
    state_t                 state;
    state_t                 state_nxt;
    logic                   unused_addr_bits;

    assign request  = p_memread_i | p_memwrite_i;
    assign idx      = p_addr_i[IDX_HI:OFFSET_W];
    assign req_tag  = p_addr_i[ADDR_W-1:IDX_HI+1];
    assign word_sel = p_addr_i[WORD_MSB:WORD_LSB];
    assign unused_addr_bits = ^p_addr_i[WORD_LSB-1:0];

    always_comb begin
        req_tag_ext              = '0;
        req_tag_ext[TAG_W-1:0]   = req_tag;
    end

    assign hit          = request & entry.valid & (entry.tag == req_tag_ext);
    assign victim_dirty = entry.valid & entry.dirty;
    assign victim_addr  = {entry.tag[TAG_W-1:0], idx, {OFFSET_W{1'b0}}};
    assign req_addr     = {req_tag, idx, {OFFSET_W{1'b0}}};

    // A simultaneous read+write is a store, so no load data is returned for it.
    assign p_data_o = (hit && p_memread_i && !p_memwrite_i)
                    ? line[{word_sel, 5'b00000} +: WORD_W] : '0;

    dcache_sram #(
        .NUM_SETS (NUM_SETS),
        .IDX_W    (IDX_W),
        .TAG_W    (TAG_W),
        .LINE_W   (LINE_W)
    ) u_sram (
        .clk       (clk_i),
        .rst       (rst_i),
        .idx       (idx),
        .entry     (entry),
        .line      (line),
        .line_we   (line_we),
        .line_tag  (req_tag),
        .line_data (mem_data_i),
        .word_we   (word_we),
        .word_sel  (word_sel),
        .word_data (p_data_i)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        p_stall_o  = 1'b1;
        mem_addr_o = '0;
        mem_data_o = '0;
        line_we    = 1'b0;
        word_we    = 1'b0;
        case (state)
            IDLE: begin
                p_stall_o = request & ~hit;
                word_we   = hit & p_memwrite_i & ~rst_i;
                if (request && !hit) begin
                    state_nxt = victim_dirty ? WB : ALLOC;
                end
            end
            WB: begin
                mem_addr_o = victim_addr;
                mem_data_o = line;
                if (mem_ack_i) begin
                    state_nxt = ALLOC;
                end
            end
            ALLOC: begin
                mem_addr_o = req_addr;
                if (mem_ack_i) begin
                    line_we   = ~rst_i;
                    state_nxt = REFILL;
                end
            end
            REFILL: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request strobes come from flops so enable stays high across the WB->ALLOC hand-off.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
        end else begin
            mem_enable_o <= (state_nxt == WB) || (state_nxt == ALLOC);
            mem_write_o  <= (state_nxt == WB);
        end
    end

`ifdef DCACHE_STATS_EN
    logic after_refill;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            after_refill <= 1'b0;
            hit_cnt_o    <= '0;
            miss_cnt_o   <= '0;
        end else begin
            after_refill <= (state == REFILL);
            if ((state == IDLE) && hit && !after_refill && (hit_cnt_o != '1)) begin
                hit_cnt_o <= hit_cnt_o + 32'd1;
            end
            if ((state == IDLE) && (state_nxt != IDLE) && (miss_cnt_o != '1)) begin
                miss_cnt_o <= miss_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
// ============================================================================
// tb_dcache_ctrl : directed bench with a memory-level reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dcache_ctrl;

    localparam int ACK_LAT = 2;
    localparam int P_READY = 0, P_WB = 1, P_RD = 2, P_REFILL = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  p_addr, p_wdata, p_rdata;
    logic         p_rd, p_wr, p_stall;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata, mem_rdata;
    logic         mem_en, mem_we, mem_ack;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_cnt, miss_cnt;
`endif

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .p_addr_i     (p_addr),
        .p_data_i     (p_wdata),
        .p_memread_i  (p_rd),
        .p_memwrite_i (p_wr),
        .p_data_o     (p_rdata),
        .p_stall_o    (p_stall),
        .mem_addr_o   (mem_addr),
        .mem_data_o   (mem_wdata),
        .mem_enable_o (mem_en),
        .mem_write_o  (mem_we),
        .mem_data_i   (mem_rdata),
`ifdef DCACHE_STATS_EN
        .hit_cnt_o    (hit_cnt),
        .miss_cnt_o   (miss_cnt),
`endif
        .mem_ack_i    (mem_ack)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
        end
    endtask

    // Reference: main memory, the CPU-visible memory image, and which lines are resident.
    logic [31:0] backing [int unsigned];
    logic [31:0] gold    [int unsigned];
    logic        m_valid [32];
    logic        m_dirty [32];
    logic [21:0] m_tag   [32];
    int          m_phase;
    logic [31:0] m_req_line, m_vict_line;
    logic        m_post_refill;
    int unsigned m_hits, m_misses;
    int          ack_wait;
    logic        model_on;

    function automatic int unsigned wa_of(input logic [31:0] a);
        return {2'b00, a[31:2]};
    endfunction
    function automatic logic [4:0]  idx_of(input logic [31:0] a); return a[9:5];   endfunction
    function automatic logic [21:0] tag_of(input logic [31:0] a); return a[31:10]; endfunction

    function automatic logic [31:0] init_word(input int unsigned wa);
        logic [31:0] w;
        w = wa;
        return {w[15:0], 16'hC0DE} ^ 32'h5A5A0000;
    endfunction
    function automatic logic [31:0] back_rd(input int unsigned wa);
        if (backing.exists(wa)) return backing[wa];
        return init_word(wa);
    endfunction
    function automatic logic [31:0] gold_rd(input int unsigned wa);
        if (gold.exists(wa)) return gold[wa];
        return back_rd(wa);
    endfunction
    function automatic logic [255:0] gold_line(input logic [31:0] la);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = gold_rd(wa_of(la) + k);
        return l;
    endfunction
    function automatic logic [255:0] back_line(input logic [31:0] la);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = back_rd(wa_of(la) + k);
        return l;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 32; s++) begin
            m_valid[s] = 1'b0;
            m_dirty[s] = 1'b0;
            m_tag[s]   = '0;
        end
        gold          = backing;
        m_phase       = P_READY;
        m_post_refill = 1'b0;
        m_hits        = 0;
        m_misses      = 0;
        ack_wait      = 0;
        mem_ack       = 1'b0;
    endtask

    logic       c_req, c_res;
    logic [4:0] c_i;

    // Compare, act as main memory, then advance the reference by one cycle.
    always @(negedge clk) begin
        if (model_on) begin
            c_req = p_rd | p_wr;
            c_i   = idx_of(p_addr);
            c_res = m_valid[c_i] && (m_tag[c_i] == tag_of(p_addr));
            case (m_phase)
                P_READY: begin
                    chk("stall", p_stall, c_req && !c_res);
                    chk("rdata", p_rdata, (c_req && p_rd && !p_wr && c_res) ? gold_rd(wa_of(p_addr)) : 32'h0);
                    chk("mem_en_idle", mem_en, 1'b0);
                    chk("mem_we_idle", mem_we, 1'b0);
                end
                P_WB: begin
                    chk("stall_wb", p_stall, 1'b1);
                    chk("mem_en_wb", mem_en, 1'b1);
                    chk("mem_we_wb", mem_we, 1'b1);
                    chk("mem_addr_wb", mem_addr, m_vict_line);
                    chk("mem_data_wb", mem_wdata, gold_line(m_vict_line));
                end
                P_RD: begin
                    chk("stall_rd", p_stall, 1'b1);
                    chk("mem_en_rd", mem_en, 1'b1);
                    chk("mem_we_rd", mem_we, 1'b0);
                    chk("mem_addr_rd", mem_addr, m_req_line);
                end
                default: begin
                    chk("stall_refill", p_stall, 1'b1);
                    chk("mem_en_refill", mem_en, 1'b0);
                end
            endcase
`ifdef DCACHE_STATS_EN
            chk("hit_cnt", hit_cnt, m_hits);
            chk("miss_cnt", miss_cnt, m_misses);
`endif
            if (mem_ack) begin
                mem_ack  = 1'b0;
                ack_wait = 0;
            end else if (m_phase == P_WB || m_phase == P_RD) begin
                if (ack_wait == ACK_LAT) mem_ack = 1'b1;
                else ack_wait++;
            end
            mem_rdata = (m_phase == P_RD) ? back_line(m_req_line) : '0;

            if (rst) begin
                model_reset();
            end else begin
                case (m_phase)
                    P_READY: begin
                        if (c_req) begin
                            if (c_res) begin
                                if (!m_post_refill) m_hits++;
                                if (p_wr) begin
                                    gold[wa_of(p_addr)] = p_wdata;
                                    m_dirty[c_i] = 1'b1;
                                end
                            end else begin
                                m_misses++;
                                m_req_line = {p_addr[31:5], 5'b0};
                                if (m_valid[c_i] && m_dirty[c_i]) begin
                                    m_vict_line = {m_tag[c_i], c_i, 5'b0};
                                    m_phase = P_WB;
                                end else begin
                                    m_phase = P_RD;
                                end
                            end
                        end
                        m_post_refill = 1'b0;
                    end
                    P_WB: if (mem_ack) begin
                        for (int k = 0; k < 8; k++)
                            backing[wa_of(m_vict_line) + k] = gold_rd(wa_of(m_vict_line) + k);
                        m_phase = P_RD;
                    end
                    P_RD: if (mem_ack) begin
                        m_valid[idx_of(m_req_line)] = 1'b1;
                        m_dirty[idx_of(m_req_line)] = 1'b0;
                        m_tag[idx_of(m_req_line)]   = tag_of(m_req_line);
                        m_phase = P_REFILL;
                    end
                    default: begin
                        m_phase = P_READY;
                        m_post_refill = 1'b1;
                    end
                endcase
            end
        end
    end

    // Per-access observations for the hand-computed expectations.
    logic [31:0] a_rdata, a_wb_addr, a_wb_w2, a_rd_addr;
    logic        a_wb, a_rd, a_en;
    int          a_stalls;

    task automatic access(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
        p_rd = rd; p_wr = wr; p_addr = addr; p_wdata = data;
        a_wb = 0; a_rd = 0; a_en = 0; a_stalls = 0;
        a_rdata = 'x; a_wb_addr = 'x; a_wb_w2 = 'x; a_rd_addr = 'x;
        forever begin
            @(negedge clk);
            if (mem_en) a_en = 1;
            if (mem_en && mem_we && !a_wb) begin
                a_wb = 1; a_wb_addr = mem_addr; a_wb_w2 = mem_wdata[95:64];
            end
            if (mem_en && !mem_we && !a_rd) begin
                a_rd = 1; a_rd_addr = mem_addr;
            end
            if (!p_stall) begin
                a_rdata = p_rdata;
                break;
            end
            a_stalls++;
            if (a_stalls > 200) begin
                chk("access_timeout", a_stalls, 0);
                break;
            end
        end
        @(posedge clk); #1;
        p_rd = 0; p_wr = 0;
    endtask

`ifdef DCACHE_STATS_EN
    logic [31:0] base_h, base_m;
`endif
    bit found;

    initial begin
        rst = 1; p_rd = 0; p_wr = 0; p_addr = 0; p_wdata = 0;
        mem_rdata = '0; model_on = 0;
        backing[1] = 32'hDEADBEEF;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 0; model_on = 1;

        @(negedge clk);
        chk("reset_stall", p_stall, 1'b0);
        chk("reset_mem_en", mem_en, 1'b0);
        chk("reset_rdata", p_rdata, 32'h0);
        @(posedge clk); #1;

        access(1, 0, 32'h0000_0004, 0);
        chk("ld4_stalls", a_stalls, 5);
        chk("ld4_alloc_addr", a_rd_addr, 32'h0);
        chk("ld4_no_wb", a_wb, 1'b0);
        chk("ld4_data", a_rdata, 32'hDEADBEEF);

        access(0, 1, 32'h0000_0008, 32'h12345678);
        chk("st8_stalls", a_stalls, 0);
        chk("st8_no_mem", a_en, 1'b0);
        access(1, 0, 32'h0000_0008, 0);
        chk("ld8_data", a_rdata, 32'h12345678);

        access(1, 0, 32'h0000_0400, 0);
        chk("ld400_wb", a_wb, 1'b1);
        chk("ld400_wb_addr", a_wb_addr, 32'h0);
        chk("ld400_wb_word2", a_wb_w2, 32'h12345678);
        chk("ld400_alloc_addr", a_rd_addr, 32'h400);
        chk("ld400_stalls", a_stalls, 9);

        access(1, 0, 32'h0000_0800, 0);
        chk("ld800_no_wb", a_wb, 1'b0);
        chk("ld800_alloc_addr", a_rd_addr, 32'h800);
        chk("ld800_stalls", a_stalls, 5);

        p_addr = 32'h0000_0C00; p_rd = 1; found = 0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clk);
            if (mem_en && !mem_we) found = 1;
        end
        chk("rst_alloc_seen", found, 1'b1);
        @(posedge clk); #1 rst = 1; p_rd = 0;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_stall", p_stall, 1'b0);
        @(posedge clk); #1;
        access(1, 0, 32'h0000_0C00, 0);
        chk("reaccess_stalls", a_stalls, 5);
        chk("reaccess_alloc", a_rd_addr, 32'hC00);

`ifdef DCACHE_STATS_EN
        base_h = hit_cnt; base_m = miss_cnt;
`endif
        access(1, 0, 32'h0000_0C00, 0);
        access(1, 0, 32'h0000_0C04, 0);
        access(1, 0, 32'h0000_1000, 0);
        access(1, 0, 32'h0000_1000, 0);
`ifdef DCACHE_STATS_EN
        chk("stats_hits", hit_cnt - base_h, 32'd3);
        chk("stats_misses", miss_cnt - base_m, 32'd1);
`endif

        access(0, 1, 32'h0000_0024, 32'hCAFEF00D);
        chk("st24_stalls", a_stalls, 5);
        access(1, 0, 32'h0000_0024, 0);
        chk("ld24_data", a_rdata, 32'hCAFEF00D);
        access(1, 1, 32'h0000_1008, 32'h0BADF00D);
        chk("rdwr_is_store", a_rdata, 32'h0);
        access(1, 0, 32'h0000_1008, 0);
        chk("ld1008_data", a_rdata, 32'h0BADF00D);
        access(1, 0, 32'h0000_0424, 0);
        chk("ld424_wb_addr", a_wb_addr, 32'h20);
        chk("ld424_stalls", a_stalls, 9);
        access(1, 0, 32'h0000_0024, 0);
        chk("ld24_after_evict", a_rdata, 32'hCAFEF00D);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
